program_loader: RTL and testbench

Boot-time instruction loader on the write side of the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit LEGv8 instruction words. Each word is written sequentially into instruction memory starting at byte address 0. On the HALT word (unconditional B with zero offset, 32'h14000000) it releases the CPU by asserting `cpu_run`; the fetch path then reads back what this block wrote.

---
 rtl/program_loader.sv | 207 ++++++++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time instruction loader.
// Accepts a byte stream over valid/ready, packs little-endian 32-bit words,
// writes them to instruction memory from byte address 0, and releases the
// CPU once the HALT word (32'h14000000) has been written.
// Optional feature: define LOADER_CHECKSUM_EN to require a one-byte XOR
// trailer after the HALT word before the CPU is released.
module program_loader #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            imem_we,
    output logic [63:0]                     imem_addr,
    output logic [31:0]                     imem_wdata,
    output logic                            cpu_run,
    output logic                            done,
    output logic                            error,
    output logic [$clog2(DEPTH_WORDS):0]    word_count
);

    localparam int              CW        = $clog2(DEPTH_WORDS) + 1;
    localparam logic [CW-1:0]   LAST_WORD = CW'(DEPTH_WORDS - 1);
    localparam logic [31:0]     HALT_WORD = 32'h1400_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [1:0]     k_r;
    logic [23:0]    lanes_r;
    logic [CW-1:0]  word_count_r;
    logic           imem_we_r;
    logic [63:0]    imem_addr_r;
    logic [31:0]    imem_wdata_r;
    logic           in_ready_s;
    logic           run_s;
    logic           error_s;
    logic           accept_s;
    logic           start_ok_s;
    logic           word_done_s;
    logic [31:0]    word_s;

    // True when a completed word is the HALT (B #0) instruction.
    function automatic logic is_halt(input logic [31:0] w);
        return (w == HALT_WORD);
    endfunction

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     checksum_r;

    // Running XOR checksum update for one accepted byte.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s    = in_valid && in_ready_s;
    assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
    assign word_done_s = accept_s && (state_r == ST_LOAD) && (k_r == 2'd3);
    assign word_s      = {in_data, lanes_r};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: start, HALT detection, overflow and trailer check.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (word_done_s) begin
                    if (is_halt(word_s)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_s = ST_CHECK;
`else
                        state_s = ST_DONE;
`endif
                    end else if (word_count_r == LAST_WORD) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (in_data == checksum_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register (Moore outputs).
    always_comb begin
        in_ready_s = 1'b0;
        run_s      = 1'b0;
        error_s    = 1'b0;
        case (state_r)
            ST_LOAD:  in_ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: in_ready_s = 1'b1;
`endif
            ST_DONE:  run_s      = 1'b1;
            ST_ERROR: error_s    = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                run_s      = 1'b0;
                error_s    = 1'b0;
            end
        endcase
    end

    // Byte lane assembly, word counter and registered memory write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r          <= 2'd0;
            lanes_r      <= 24'd0;
            word_count_r <= {CW{1'b0}};
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 64'd0;
            imem_wdata_r <= 32'd0;
        end else begin
            imem_we_r <= 1'b0;
            if (start_ok_s) begin
                k_r          <= 2'd0;
                lanes_r      <= 24'd0;
                word_count_r <= {CW{1'b0}};
            end else if (accept_s && (state_r == ST_LOAD)) begin
                k_r <= k_r + 2'd1;
                case (k_r)
                    2'd0: lanes_r[7:0]   <= in_data;
                    2'd1: lanes_r[15:8]  <= in_data;
                    2'd2: lanes_r[23:16] <= in_data;
                    2'd3: begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= {{(64-CW-2){1'b0}}, word_count_r, 2'b00};
                        imem_wdata_r <= word_s;
                        word_count_r <= word_count_r + CW'(1);
                    end
                    default: lanes_r <= lanes_r;
                endcase
            end else begin
                k_r <= k_r;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // XOR of every byte accepted during LOAD of the current load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_r <= 8'd0;
        end else if (start_ok_s) begin
            checksum_r <= 8'd0;
        end else if (accept_s && (state_r == ST_LOAD)) begin
            checksum_r <= xor_fold(checksum_r, in_data);
        end else begin
            checksum_r <= checksum_r;
        end
    end
`endif

    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_run    = run_s;
    assign done       = run_s;
    assign error      = error_s;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (default depth) plus a
// small-depth instance for the overflow case.
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    logic        start4;
    logic [7:0]  in_data4;
    logic        in_valid4;
    logic        in_ready4;
    logic        imem_we4;
    logic [63:0] imem_addr4;
    logic [31:0] imem_wdata4;
    logic        cpu_run4;
    logic        done4;
    logic        error4;
    logic [2:0]  word_count4;

    int total = 0;
    int bad   = 0;

    program_loader #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
        .done(done), .error(error), .word_count(word_count)
    );

    program_loader #(.DEPTH_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .in_data(in_data4),
        .in_valid(in_valid4), .in_ready(in_ready4), .imem_we(imem_we4),
        .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .cpu_run(cpu_run4),
        .done(done4), .error(error4), .word_count(word_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  d;
        logic        we;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        run;
        logic        err;
        logic [10:0] wc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic vld, input logic [7:0] d, input logic we,
                       input logic [63:0] addr, input logic [31:0] wdata, input logic rdy,
                       input logic run, input logic err, input logic [10:0] wc);
        vec_t v;
        v.st = st; v.vld = vld; v.d = d; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rdy = rdy; v.run = run; v.err = err; v.wc = wc;
        tbl.push_back(v);
    endtask

    // Program 21 04 00 91 00 00 00 14 (+ trailer A0 with checksum); optional idle gaps.
    task automatic add_load(input bit toggle);
        logic [7:0]  bytes [8];
        logic [31:0] words [2];
        logic [10:0] wc;
        bit          halt;
        bytes = '{8'h21, 8'h04, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'h14};
        words = '{32'h9100_0421, 32'h1400_0000};
        for (int i = 0; i < 8; i++) begin
            halt = (i == 7);
            wc   = 11'((i + 1) / 4);
            add(1'b0, 1'b1, bytes[i], (i % 4) == 3, 64'((i / 4) * 4), words[i / 4],
                !halt || CK, halt && !CK, 1'b0, wc);
            if (toggle) begin
                add(i == 1, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, !halt || CK, halt && !CK, 1'b0, wc);
            end
        end
        if (CK) begin
            add(1'b0, 1'b1, 8'hA0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd2);
            if (toggle) begin
                add(1'b0, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd2);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [8];
        prog = '{8'h21, 8'h04, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'h14};
        reset = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        start4 = 1'b0; in_data4 = 8'h00; in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        chk("rst_ready", 0, 64'(in_ready), 64'd0);
        chk("rst_we",    0, 64'(imem_we), 64'd0);
        chk("rst_addr",  0, imem_addr, 64'd0);
        chk("rst_wdata", 0, 64'(imem_wdata), 64'd0);
        chk("rst_run",   0, 64'(cpu_run), 64'd0);
        chk("rst_done",  0, 64'(done), 64'd0);
        chk("rst_err",   0, 64'(error), 64'd0);
        chk("rst_wc",    0, 64'(word_count), 64'd0);

        // Table: full-rate load, idle, toggled reload (start mid-load ignored), single-HALT reload
        add(1'b1, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        add_load(1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd2);
        add(1'b1, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        add_load(1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 1'b1, 8'h00, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0);
        end
        add(1'b0, 1'b1, 8'h14, 1'b1, 64'd0, 32'h1400_0000, CK, !CK, 1'b0, 11'd1);
        if (CK) begin
            add(1'b0, 1'b1, 8'h14, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd1);
        end
        add(1'b0, 1'b0, 8'h00, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0, 11'd1);

        foreach (tbl[i]) begin
            start    = tbl[i].st;
            in_valid = tbl[i].vld;
            in_data  = tbl[i].d;
            step();
            chk("we", i, 64'(imem_we), 64'(tbl[i].we));
            if (tbl[i].we) begin
                chk("addr",  i, imem_addr, tbl[i].addr);
                chk("wdata", i, 64'(imem_wdata), 64'(tbl[i].wdata));
            end
            chk("ready", i, 64'(in_ready), 64'(tbl[i].rdy));
            chk("run",   i, 64'(cpu_run), 64'(tbl[i].run));
            chk("done",  i, 64'(done), 64'(tbl[i].run));
            chk("err",   i, 64'(error), 64'(tbl[i].err));
            chk("wc",    i, 64'(word_count), 64'(tbl[i].wc));
        end
        start = 1'b0; in_valid = 1'b0;

        // Checksum mismatch: trailer A1 instead of A0
        if (CK) begin
            start = 1'b1; step(); start = 1'b0;
            for (int i = 0; i < 8; i++) send(prog[i]);
            send(8'hA1);
            chk("ck_err",   0, 64'(error), 64'd1);
            chk("ck_run",   0, 64'(cpu_run), 64'd0);
            chk("ck_done",  0, 64'(done), 64'd0);
            chk("ck_ready", 0, 64'(in_ready), 64'd0);
        end

        // Reset after 6 bytes: asynchronous clear, then a fresh HALT-only load
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) send(prog[i]);
        #2 reset = 1'b1;
        #1;
        chk("mid_ready", 0, 64'(in_ready), 64'd0);
        chk("mid_we",    0, 64'(imem_we), 64'd0);
        chk("mid_addr",  0, imem_addr, 64'd0);
        chk("mid_wdata", 0, 64'(imem_wdata), 64'd0);
        chk("mid_run",   0, 64'(cpu_run), 64'd0);
        chk("mid_done",  0, 64'(done), 64'd0);
        chk("mid_err",   0, 64'(error), 64'd0);
        chk("mid_wc",    0, 64'(word_count), 64'd0);
        step();
        reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        send(8'h00); send(8'h00); send(8'h00); send(8'h14);
        chk("re_we",    0, 64'(imem_we), 64'd1);
        chk("re_addr",  0, imem_addr, 64'd0);
        chk("re_wdata", 0, 64'(imem_wdata), 64'h1400_0000);
        chk("re_wc",    0, 64'(word_count), 64'd1);
        if (CK) send(8'h14);
        chk("re_run",   0, 64'(cpu_run), 64'd1);

        // Overflow on the 4-word instance: four non-HALT words
        start4 = 1'b1; step(); start4 = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                in_valid4 = 1'b1;
                in_data4  = (b == 0) ? 8'(w + 1) : 8'h00;
                step();
            end
            in_valid4 = 1'b0;
            chk("ov_we",    w, 64'(imem_we4), 64'd1);
            chk("ov_addr",  w, imem_addr4, 64'(w * 4));
            chk("ov_wdata", w, 64'(imem_wdata4), 64'(w + 1));
            chk("ov_err",   w, 64'(error4), 64'(w == 3));
            chk("ov_ready", w, 64'(in_ready4), 64'(w != 3));
        end
        chk("ov_run", 0, 64'(cpu_run4), 64'd0);
        chk("ov_wc",  0, 64'(word_count4), 64'd4);
        step();
        chk("ov_we_drop", 0, 64'(imem_we4), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
